// File: rtl/alu_pkg.sv
// alu_pkg: shared FunSel codes, wide opcode enum and flag indices for the 16-bit ALU
//   FS_*     : 5-bit FunSel codes understood by the 16-bit ALU
//   in_op_t  : 32-bit operation codes accepted by alu_wide_sequencer
//   FLG_*    : bit positions of Z C N O inside a 4-bit flag vector
package alu_pkg;

   localparam logic [4:0] FS_MOVA16 = 5'b10000;
   localparam logic [4:0] FS_NOTA16 = 5'b10010;
   localparam logic [4:0] FS_ADD16  = 5'b10100;
   localparam logic [4:0] FS_ADC16  = 5'b10101;
   localparam logic [4:0] FS_AND16  = 5'b10111;
   localparam logic [4:0] FS_OR16   = 5'b11000;
   localparam logic [4:0] FS_XOR16  = 5'b11001;

   typedef enum logic [2:0] {
      OP_MOV32 = 3'b000,
      OP_NOT32 = 3'b001,
      OP_ADD32 = 3'b010,
      OP_AND32 = 3'b011,
      OP_OR32  = 3'b100,
      OP_XOR32 = 3'b101
   } in_op_t;

   localparam int FLG_Z = 3;
   localparam int FLG_C = 2;
   localparam int FLG_N = 1;
   localparam int FLG_O = 0;

   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_XOR32;
   endfunction

   // The high half of an add chains the low-half carry, so it uses add-with-carry.
   function automatic logic [4:0] funsel_of(input logic [2:0] op, input logic hi);
      return (op == OP_NOT32) ? FS_NOTA16 :
             (op == OP_ADD32) ? (hi ? FS_ADC16 : FS_ADD16) :
             (op == OP_AND32) ? FS_AND16 :
             (op == OP_OR32)  ? FS_OR16 :
             (op == OP_XOR32) ? FS_XOR16 : FS_MOVA16;
   endfunction

endpackage

// File: rtl/wide_seq_flag_merge.sv
// wide_seq_flag_merge: combinational merge of 32-bit Z C N O flags
//   result   in  W  assembled wide result
//   op       in  3  latched wide opcode
//   flags_in in  4  ALU registered flags sampled after the high pass
//   flags    out 4  merged Z C N O
module wide_seq_flag_merge
   import alu_pkg::*;
#(
   parameter int W = 32
)
(
   input  logic [W-1:0] result,
   input  logic [2:0]   op,
   input  logic [3:0]   flags_in,
   output logic [3:0]   flags
);

   logic is_add;
   logic unused_flags;

   assign is_add = op == OP_ADD32;
   // Z and N of the ALU only describe the high half, so they are recomputed here.
   assign unused_flags = flags_in[FLG_Z] ^ flags_in[FLG_N];

   always_comb begin
      flags = '0;
      flags[FLG_Z] = result == '0;
      flags[FLG_C] = is_add & flags_in[FLG_C];
      flags[FLG_N] = result[W-1];
      flags[FLG_O] = is_add & flags_in[FLG_O];
   end

endmodule

// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: splits 32-bit operations into two 16-bit ALU passes, low half first
//   Clock, Reset                 clock and synchronous active-high reset
//   InValid/InReady, InOp/InA/InB request handshake and operands
//   OutValid/OutReady, OutResult/OutFlags/OutErr  response handshake and result
//   OvfTrap                      sticky overflow trap (only with WIDE_SEQ_OVF_TRAP_EN defined)
//   FunSel, A, B, WF             ALU control and operands
//   ALUOut, FlagsOut             ALU combinational result and registered flags
module alu_wide_sequencer
   import alu_pkg::*;
#(
   parameter int HALF_W = 16
)
(
   input  logic                Clock,
   input  logic                Reset,
   input  logic                InValid,
   output logic                InReady,
   input  logic [2:0]          InOp,
   input  logic [2*HALF_W-1:0] InA,
   input  logic [2*HALF_W-1:0] InB,
   output logic                OutValid,
   input  logic                OutReady,
   output logic [2*HALF_W-1:0] OutResult,
   output logic [3:0]          OutFlags,
   output logic                OutErr,
   output logic                OvfTrap,
   output logic [4:0]          FunSel,
   output logic [HALF_W-1:0]   A,
   output logic [HALF_W-1:0]   B,
   output logic                WF,
   input  logic [HALF_W-1:0]   ALUOut,
   input  logic [3:0]          FlagsOut
);

   typedef enum logic [2:0] {IDLE, LO, HI, FLAGS, RESP} state_t;

   state_t              state, state_n;
   logic [2:0]          op;
   logic [2*HALF_W-1:0] a, b, result;
   logic [3:0]          flags, merged;
   logic                err, accept, legal;

   assign accept    = (state == IDLE) & InValid;
   assign legal     = op_legal(InOp);
   assign InReady   = state == IDLE;
   assign OutValid  = state == RESP;
   assign OutResult = result;
   assign OutFlags  = flags;
   assign OutErr    = err;

   always_ff @(posedge Clock) begin
      if (Reset) state <= IDLE;
      else state <= state_n;
   end

   always_comb begin
      state_n = state;
      FunSel = FS_MOVA16;
      A = '0;
      B = '0;
      WF = 1'b0;
      case (state)
         IDLE: if (InValid) state_n = legal ? LO : RESP;
         LO: begin
            state_n = HI;
            FunSel = funsel_of(op, 1'b0);
            A = a[HALF_W-1:0];
            B = b[HALF_W-1:0];
            WF = 1'b1;
         end
         HI: begin
            state_n = FLAGS;
            FunSel = funsel_of(op, 1'b1);
            A = a[2*HALF_W-1:HALF_W];
            B = b[2*HALF_W-1:HALF_W];
            WF = 1'b1;
         end
         FLAGS: state_n = RESP;
         RESP: if (OutReady) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         op <= OP_MOV32;
         a <= '0;
         b <= '0;
         result <= '0;
         flags <= '0;
         err <= 1'b0;
      end else begin
         if (accept) begin
            op <= InOp;
            a <= InA;
            b <= InB;
            err <= !legal;
            // Illegal requests skip the ALU, so clear the result here.
            if (!legal) begin
               result <= '0;
               flags <= '0;
            end
         end
         if (state == LO) result[HALF_W-1:0] <= ALUOut;
         if (state == HI) result[2*HALF_W-1:HALF_W] <= ALUOut;
         if (state == FLAGS) flags <= merged;
      end
   end

   wide_seq_flag_merge #(.W(2*HALF_W)) u_flag_merge (
      .result  (result),
      .op      (op),
      .flags_in(FlagsOut),
      .flags   (merged)
   );

`ifdef WIDE_SEQ_OVF_TRAP_EN
   logic ovf_trap;

   always_ff @(posedge Clock) begin
      if (Reset) ovf_trap <= 1'b0;
      else if (state == FLAGS && op == OP_ADD32 && merged[FLG_O]) ovf_trap <= 1'b1;
   end

   assign OvfTrap = ovf_trap;
`else
   assign OvfTrap = 1'b0;
`endif

endmodule
